// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD conversion blocks.
//   state_t    : sequencer states (IDLE, SHIFT, DONE)
//   nibble_t   : one packed BCD digit
//   BCD_MAX    : largest value representable in BCD_DIGITS decimal digits
//   BCD_DIGITS : number of decimal digits produced
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef logic [3:0] nibble_t;

  localparam int BCD_MAX    = 9999;
  localparam int BCD_DIGITS = 4;

endpackage

// File: rtl/dabble_correct.sv
// Double-dabble digit correction: adds 3 to a BCD nibble that is 5 or more,
// so that the following left shift carries correctly into the next digit.
//   din  : accumulator nibble before the shift
//   dout : corrected nibble
module dabble_correct
  import bcd_pkg::*;
(
  input  nibble_t din,
  output nibble_t dout
);

  assign dout = (din >= nibble_t'(5)) ? din + nibble_t'(3) : din;

endmodule

// File: rtl/bin2bcd_sequencer.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one clock per input bit.
//   Clock    : rising-edge clock
//   Reset    : asynchronous, active-high
//   Start    : request a conversion (sampled when not busy)
//   Input    : unsigned operand, captured on the accepting edge
//   Busy     : conversion in progress
//   Done     : one-cycle pulse, digits valid and freshly updated
//   Overflow : last result exceeded 9999 (digits saturated to 9999)
//   Digit3..Digit0 : thousands .. units, registered and held
module bin2bcd_sequencer
  import bcd_pkg::*;
#(
  parameter int INPUT_BIT_WIDTH = 16
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic [INPUT_BIT_WIDTH-1:0] Input,
  output logic                       Busy,
  output logic                       Done,
  output logic                       Overflow,
  output logic [0:3]                 Digit3,
  output logic [0:3]                 Digit2,
  output logic [0:3]                 Digit1,
  output logic [0:3]                 Digit0
);

  localparam int CW = $clog2(INPUT_BIT_WIDTH + 1);

  generate
    if (INPUT_BIT_WIDTH < 4 || INPUT_BIT_WIDTH > 32) begin : g_bad_width
      $error("bin2bcd_sequencer: INPUT_BIT_WIDTH must be in 4..32");
    end
  endgenerate

  state_t                     state, state_next;
  logic                       accept;
  logic [INPUT_BIT_WIDTH-1:0] bin, bin_shift;
  logic [15:0]                acc, acc_corr, acc_shift;
  logic [CW-1:0]              cnt;
  logic                       ovf_pending;
  logic                       last_shift;

  // Correct every digit first, then shift; the MSB falling off acc only
  // happens for operands above 9999, whose result is saturated anyway.
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_dabble
    dabble_correct u_dabble (
      .din  (acc[4*g +: 4]),
      .dout (acc_corr[4*g +: 4])
    );
  end

  assign acc_shift  = {acc_corr[14:0], bin[INPUT_BIT_WIDTH-1]};
  assign bin_shift  = {bin[INPUT_BIT_WIDTH-2:0], 1'b0};
  assign last_shift = (state == SHIFT) && (cnt == CW'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        Busy = 1'b1;
        if (cnt == CW'(1)) state_next = DONE;
      end
      DONE: begin
        Done = 1'b1;
        if (Start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      bin         <= '0;
      acc         <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      Overflow    <= 1'b0;
      Digit3      <= '0;
      Digit2      <= '0;
      Digit1      <= '0;
      Digit0      <= '0;
    end else if (accept) begin
      bin         <= Input;
      acc         <= '0;
      cnt         <= CW'(INPUT_BIT_WIDTH);
      ovf_pending <= 32'(Input) > 32'(BCD_MAX);
    end else if (state == SHIFT) begin
      acc <= acc_shift;
      bin <= bin_shift;
      cnt <= cnt - CW'(1);
      // Digits load from the post-shift value on the edge that enters DONE.
      if (last_shift) begin
        Overflow <= ovf_pending;
        if (ovf_pending) begin
          Digit3 <= 4'd9;
          Digit2 <= 4'd9;
          Digit1 <= 4'd9;
          Digit0 <= 4'd9;
        end else begin
          Digit3 <= acc_shift[15:12];
          Digit2 <= acc_shift[11:8];
          Digit1 <= acc_shift[7:4];
          Digit0 <= acc_shift[3:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_sequencer.sv
// Self-checking bench for bin2bcd_sequencer at the default 16-bit width.
// Expected digits come from plain decimal arithmetic on the operand.
module tb_bin2bcd_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] inp = '0;
  logic         busy, done, overflow;
  logic [0:3]   d3, d2, d1, d0;

  int n_checks = 0;
  int n_fail   = 0;

  bin2bcd_sequencer #(.INPUT_BIT_WIDTH(W)) dut (
    .Clock    (clk),
    .Reset    (rst),
    .Start    (start),
    .Input    (inp),
    .Busy     (busy),
    .Done     (done),
    .Overflow (overflow),
    .Digit3   (d3),
    .Digit2   (d2),
    .Digit1   (d1),
    .Digit0   (d0)
  );

  always #5 clk = ~clk;

  // Reference: {overflow, four BCD digits} from ordinary integer arithmetic.
  function automatic logic [16:0] ref_bcd(input int unsigned v);
    if (v > 9999) return {1'b1, 16'h9999};
    return {1'b0, 4'(v / 1000), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] digits();
    return {d3, d2, d1, d0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full handshake: Start for one edge, count Busy cycles, check the Done
  // cycle and the result, then confirm Done drops.
  task automatic convert(input logic [W-1:0] v);
    logic [16:0] exp;
    int busy_cnt;
    exp = ref_bcd(v);
    @(negedge clk);
    start = 1'b1;
    inp   = v;
    @(negedge clk);
    start = 1'b0;
    inp   = ~v;
    busy_cnt = 0;
    for (int i = 0; i < W; i++) begin
      if (busy && !done) busy_cnt++;
      @(negedge clk);
    end
    check("busy_cycles", busy_cnt, W);
    check("done_at_latency", done, 1'b1);
    check("busy_in_done", busy, 1'b0);
    check("digits", digits(), exp[15:0]);
    check("overflow", overflow, exp[16]);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("digits_held", digits(), exp[15:0]);
    check("overflow_held", overflow, exp[16]);
  endtask

  initial begin
    int done_cnt;
    logic [16:0] exp;

    // Reset state
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_digits", digits(), 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Zero, small values, boundaries
    convert(16'd0);
    convert(16'd10);
    convert(16'd142);
    convert(16'd89);
    convert(16'd33);
    convert(16'd599);
    convert(16'd9999);
    convert(16'd10000);
    convert(16'd65535);
    convert(16'd7);

    // Start held high: results every W+1 clocks; mid-run Input change only
    // reaches the following conversion.
    @(negedge clk);
    start = 1'b1;
    inp   = 16'd1234;
    done_cnt = 0;
    for (int n = 1; n <= 3 * (W + 1); n++) begin
      @(negedge clk);
      if (n == 5) inp = 16'd4321;
      check("b2b_done", done, (n % (W + 1)) == 0);
      if (done) begin
        exp = ref_bcd((done_cnt == 0) ? 1234 : 4321);
        check("b2b_digits", digits(), exp[15:0]);
        check("b2b_overflow", overflow, 1'b0);
        done_cnt++;
      end
      if (n == 3 * (W + 1)) start = 1'b0;
    end
    check("b2b_done_count", done_cnt, 3);
    @(negedge clk);
    check("b2b_idle", busy | done, 1'b0);

    // Start while busy is ignored
    @(negedge clk);
    start = 1'b1;
    inp   = 16'd599;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    for (int n = 1; n <= 2 * (W + 1) + 4; n++) begin
      if (n == 5) begin
        start = 1'b1;
        inp   = 16'd33;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        check("ignore_digits", digits(), 16'h0599);
        done_cnt++;
      end
      @(negedge clk);
    end
    check("ignore_done_count", done_cnt, 1);

    // Async reset mid-conversion, with Overflow set beforehand
    convert(16'd50000);
    @(negedge clk);
    start = 1'b1;
    inp   = 16'd599;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n < 8; n++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_overflow", overflow, 1'b0);
    check("arst_digits", digits(), 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int n = 0; n < 2 * (W + 1); n++) begin
      if (done || busy) done_cnt++;
      @(negedge clk);
    end
    check("arst_no_activity", done_cnt, 0);
    convert(16'd599);

    // Random operands over the full 16-bit range
    for (int k = 0; k < 20; k++) convert(W'($urandom_range(0, 65535)));
    convert(W'($urandom_range(0, 9999)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
